// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC, NOP encoding and
// the output-register source select.
package instr_fetch_pkg;

   localparam int unsigned AddrW = 16;
   localparam int unsigned DataW = 16;
   localparam logic [15:0] ResetPc = 16'h0000;
   localparam logic [15:0] InstrNop = 16'h0000;

   typedef enum logic [1:0] {
      OutHold,
      OutSkid,
      OutRsp,
      OutEmpty
   } out_sel_e;

endpackage

// File: rtl/instr_fetch_skid_buf.sv
// One-entry {pc,data} skid buffer. Flush beats capture, and capture beats
// release. v_next_o exposes the next occupancy so fetch can throttle issue.
module instr_fetch_skid_buf
   import instr_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = AddrW,
   parameter int unsigned DATA_W = DataW
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              capture_i,
   input  logic              release_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              v_o,
   output logic              v_next_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [DATA_W-1:0] data_o
);

   logic              v_q, v_d;
   logic [ADDR_W-1:0] pc_q;
   logic [DATA_W-1:0] data_q;

   always_comb begin
      v_d = v_q;
      if (flush_i) begin
         v_d = 1'b0;
      end else if (capture_i) begin
         v_d = 1'b1;
      end else if (release_i) begin
         v_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v_q    <= 1'b0;
         pc_q   <= '0;
         data_q <= '0;
      end else begin
         v_q <= v_d;
         if (capture_i && !flush_i) begin
            pc_q   <= pc_i;
            data_q <= data_i;
         end
      end
   end

   assign v_o      = v_q;
   assign v_next_o = v_d;
   assign pc_o     = pc_q;
   assign data_o   = data_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: sequences the ROM address, tracks the 1-cycle ROM read,
// and feeds decode through a registered valid/ready output with a skid entry.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int unsigned     ADDR_W   = AddrW,
   parameter int unsigned     DATA_W   = DataW,
   parameter logic [ADDR_W-1:0] RESET_PC = ResetPc
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_q,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready
);

   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              rsp_v_q, rsp_v_d;
   logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
   logic              instr_valid_q, instr_valid_d;

   logic              out_free, issue;
   logic              skid_v, skid_v_next, skid_capture, skid_release;
   logic [ADDR_W-1:0] skid_pc;
   logic [DATA_W-1:0] skid_data;
   out_sel_e          out_sel;

   assign out_free     = !instr_valid_q || instr_ready;
   // A response that cannot land in the output register parks in the skid.
   assign skid_capture = !out_free && rsp_v_q && !skid_v;
   assign skid_release = out_free && skid_v;
   // Never issue a read whose response would have nowhere to go.
   assign issue        = fetch_en && !skid_v_next;

   instr_fetch_skid_buf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_skid (
      .clk_i     (clk),
      .rst_i     (reset),
      .capture_i (skid_capture),
      .release_i (skid_release),
      .flush_i   (redirect_valid),
      .pc_i      (rsp_pc_q),
      .data_i    (rom_q),
      .v_o       (skid_v),
      .v_next_o  (skid_v_next),
      .pc_o      (skid_pc),
      .data_o    (skid_data)
   );

   always_comb begin
      rom_addr_d = rom_addr_q;
      rsp_v_d    = 1'b0;
      rsp_pc_d   = rsp_pc_q;
      if (redirect_valid) begin
         rom_addr_d = redirect_pc;
      end else if (issue) begin
         rsp_v_d    = 1'b1;
         rsp_pc_d   = rom_addr_q;
         rom_addr_d = rom_addr_q + ADDR_W'(1);
      end
   end

   always_comb begin
      out_sel = OutHold;
      if (redirect_valid) begin
         out_sel = OutEmpty;
      end else if (out_free && skid_v) begin
         out_sel = OutSkid;
      end else if (out_free && rsp_v_q) begin
         out_sel = OutRsp;
      end else if (out_free) begin
         out_sel = OutEmpty;
      end
   end

   always_comb begin
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      unique case (out_sel)
         OutSkid: begin
            instr_d       = skid_data;
            instr_pc_d    = skid_pc;
            instr_valid_d = 1'b1;
         end
         OutRsp: begin
            instr_d       = rom_q;
            instr_pc_d    = rsp_pc_q;
            instr_valid_d = 1'b1;
         end
         OutEmpty: instr_valid_d = 1'b0;
         OutHold:  ;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rom_addr_q    <= RESET_PC;
         rsp_v_q       <= 1'b0;
         rsp_pc_q      <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         rom_addr_q    <= rom_addr_d;
         rsp_v_q       <= rsp_v_d;
         rsp_pc_q      <= rsp_pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   assign rom_addr    = rom_addr_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch against a ROM holding M[n] = 16'h1000 + n.
module tb_instr_fetch;

   logic        clk;
   logic        reset;
   logic        fetch_en;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic [15:0] rom_addr;
   logic [15:0] rom_q;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;

   int n_checks = 0;
   int n_fails  = 0;

   instr_fetch u_dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .rom_addr       (rom_addr),
      .rom_q          (rom_q),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk) rom_q <= 16'h1000 + rom_addr;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [15:0] pc, input logic [15:0] data);
      check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
      check_eq({tag, "_pc"}, 32'(instr_pc), 32'(pc));
      check_eq({tag, "_instr"}, 32'(instr), 32'(data));
   endtask

   logic [15:0] wrap_pc [4];
   logic [15:0] wrap_data [4];

   initial begin
      wrap_pc   = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      wrap_data = '{16'h0FFE, 16'h0FFF, 16'h1000, 16'h1001};

      reset          = 1'b1;
      fetch_en       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0;
      instr_ready    = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("rst_valid", 32'(instr_valid), 32'd0);
      check_eq("rst_addr", 32'(rom_addr), 32'h0);
      check_eq("rst_instr", 32'(instr), 32'h0);
      check_eq("rst_pc", 32'(instr_pc), 32'h0);

      // Start-up latency and streaming
      reset = 1'b0;
      @(negedge clk);
      check_eq("t1_edge1_valid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_out($sformatf("t1_seq%0d", i), 16'(i), 16'h1000 + 16'(i));
      end

      // Stall with skid capture, then resume
      @(negedge clk);
      check_out("t2_pc4", 16'h0004, 16'h1004);
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_out($sformatf("t2_hold%0d", i), 16'h0004, 16'h1004);
      end
      instr_ready = 1'b1;
      for (int i = 5; i < 8; i++) begin
         @(negedge clk);
         check_out($sformatf("t2_resume%0d", i), 16'(i), 16'h1000 + 16'(i));
      end

      // Redirect mid-stream
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0040;
      @(negedge clk);
      redirect_valid = 1'b0;
      check_eq("t3_flush_valid", 32'(instr_valid), 32'd0);
      check_eq("t3_rom_addr", 32'(rom_addr), 32'h0040);
      @(negedge clk);
      check_eq("t3_edge1_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      check_out("t3_tgt", 16'h0040, 16'h1040);
      @(negedge clk);
      check_out("t3_next", 16'h0041, 16'h1041);

      // Redirect while stalled with the skid full
      instr_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_out("t4_stalled", 16'h0041, 16'h1041);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0080;
      @(negedge clk);
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      check_eq("t4_flush_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      check_eq("t4_edge1_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      check_out("t4_tgt", 16'h0080, 16'h1080);
      @(negedge clk);
      check_out("t4_next", 16'h0081, 16'h1081);

      // Address wrap-around
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFE;
      @(negedge clk);
      redirect_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_out($sformatf("t5_wrap%0d", i), wrap_pc[i], wrap_data[i]);
      end

      // fetch_en low: drain the in-flight read, then go idle with address frozen
      fetch_en = 1'b0;
      @(negedge clk);
      check_out("t7_drain", 16'h0002, 16'h1002);
      check_eq("t7_addr_frozen0", 32'(rom_addr), 32'h0003);
      @(negedge clk);
      check_eq("t7_idle_valid", 32'(instr_valid), 32'd0);
      check_eq("t7_addr_frozen1", 32'(rom_addr), 32'h0003);

      // Asynchronous reset pulse between edges
      fetch_en = 1'b1;
      #2 reset = 1'b1;
      #1;
      check_eq("t6_async_valid", 32'(instr_valid), 32'd0);
      check_eq("t6_async_addr", 32'(rom_addr), 32'h0);
      check_eq("t6_async_instr", 32'(instr), 32'h0);
      #1 reset = 1'b0;
      @(negedge clk);
      check_eq("t6_edge1_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      check_out("t6_restart0", 16'h0000, 16'h1000);
      @(negedge clk);
      check_out("t6_restart1", 16'h0001, 16'h1001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
